// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step
// per clock, with sign handling on entry and exit. Fixed latency for every op.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         funct_q, funct_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               out_valid_q, out_valid_d;

   logic               signed_a, signed_b, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_sel, res;

   // Operand signedness: MULHSU/MULHU/DIVU/REMU treat one or both operands as unsigned.
   always_comb begin
      signed_a = funct[2] ? !funct[0] : (funct[1:0] != 2'b11);
      signed_b = funct[2] ? !funct[0] : !funct[1];
      a_neg    = signed_a & A[WIDTH-1];
      b_neg    = signed_b & B[WIDTH-1];
      b_zero   = (B == '0);
      mag_a    = a_neg ? '0 - A : A;
      mag_b    = b_neg ? '0 - B : B;
   end

   // acc_q holds {partial product, multiplier} for mul and {remainder, quotient} for div.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & op_q};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, op_q};
      div_ge    = div_shift >= {1'b0, op_q};
      prod_fix  = neg_q ? '0 - acc_q : acc_q;
      div_sel   = funct_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      if (funct_q[2]) begin
         res = neg_q ? '0 - div_sel : div_sel;
      end else begin
         res = (funct_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      funct_d     = funct_q;
      neg_d       = neg_q;
      op_d        = op_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               funct_d = funct;
               // Divide-by-zero keeps the all-ones quotient unsigned; remainder follows A.
               neg_d   = funct[2] ? (funct[1] ? a_neg : (a_neg ^ b_neg) & !b_zero)
                                  : (a_neg ^ b_neg);
               op_d    = funct[2] ? mag_b : mag_a;
               acc_d   = {{WIDTH{1'b0}}, funct[2] ? mag_a : mag_b};
               cnt_d   = CW'(WIDTH);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
               if (funct_q[2]) begin
                  acc_d = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end else begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end
            end else begin
               // Sign fix-up gets its own edge after the last step.
               out_d       = res;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (kill) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         funct_q     <= '0;
         neg_q       <= 1'b0;
         op_q        <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         funct_q     <= funct_d;
         neg_q       <= neg_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign Out       = out_q;

endmodule
